pipe_stage_buf: RTL

- Parametrised pipeline stage register, the successor to the fixed 16-bit IF/ID latch.
- Carries a DATA_W payload between any two pipeline stages (IF/ID, ID/EX, ...) with a valid/ready handshake.
- Includes a 2-entry skid buffer, so upstream ready is a registered signal.
- Adds synchronous flush with NOP injection and a first-after-reset marker.

---
 rtl/pipe_stage_buf.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: parametrised pipeline stage register with a valid/ready
// handshake and a 2-entry skid buffer (main + skid), so in_ready is a
// registered signal. Supports synchronous flush with NOP injection and a
// first-after-reset marker travelling alongside each entry.
// Optional macro PIPE_STAGE_STATS_EN builds a saturating downstream-stall
// counter on stall_cnt; without it stall_cnt is tied to zero.
module pipe_stage_buf #(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}},
    parameter int                CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_first,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_r;
    logic [DATA_W-1:0]   main_r;
    logic [DATA_W-1:0]   skid_r;
    logic                main_first_r;
    logic                skid_first_r;
    logic                first_arm_r;
    logic                in_ready_r;
    logic                out_valid_r;
    logic                accept_s;
    logic                deliver_s;

    // Handshake qualifiers; both use only registered readiness/validity.
    assign accept_s  = in_valid & in_ready_r;
    assign deliver_s = out_valid_r & out_ready;

    // Entry storage, occupancy state and registered handshake outputs.
    // Empty slots are always held at NOP_VAL with a cleared flag, so the
    // head register can drive out_data/out_first directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_EMPTY;
            main_r       <= NOP_VAL;
            skid_r       <= NOP_VAL;
            main_first_r <= 1'b0;
            skid_first_r <= 1'b0;
            first_arm_r  <= 1'b1;
            in_ready_r   <= 1'b0;
            out_valid_r  <= 1'b0;
        end else if (flush) begin
            // Flush wins: drop everything, including a same-cycle accept.
            state_r      <= ST_EMPTY;
            main_r       <= NOP_VAL;
            skid_r       <= NOP_VAL;
            main_first_r <= 1'b0;
            skid_first_r <= 1'b0;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    in_ready_r <= 1'b1;
                    if (accept_s) begin
                        main_r       <= in_data;
                        main_first_r <= first_arm_r;
                        first_arm_r  <= 1'b0;
                        state_r      <= ST_ONE;
                        out_valid_r  <= 1'b1;
                    end else begin
                        out_valid_r  <= 1'b0;
                    end
                end
                ST_ONE: begin
                    if (accept_s && deliver_s) begin
                        main_r       <= in_data;
                        main_first_r <= first_arm_r;
                        first_arm_r  <= 1'b0;
                    end else if (accept_s) begin
                        skid_r       <= in_data;
                        skid_first_r <= first_arm_r;
                        first_arm_r  <= 1'b0;
                        state_r      <= ST_FULL;
                        in_ready_r   <= 1'b0;
                    end else if (deliver_s) begin
                        main_r       <= NOP_VAL;
                        main_first_r <= 1'b0;
                        state_r      <= ST_EMPTY;
                        out_valid_r  <= 1'b0;
                    end else begin
                        state_r      <= ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (deliver_s) begin
                        main_r       <= skid_r;
                        main_first_r <= skid_first_r;
                        skid_r       <= NOP_VAL;
                        skid_first_r <= 1'b0;
                        state_r      <= ST_ONE;
                        in_ready_r   <= 1'b1;
                    end else begin
                        state_r      <= ST_FULL;
                    end
                end
                default: begin
                    state_r      <= ST_EMPTY;
                    main_r       <= NOP_VAL;
                    skid_r       <= NOP_VAL;
                    main_first_r <= 1'b0;
                    skid_first_r <= 1'b0;
                    in_ready_r   <= 1'b1;
                    out_valid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = main_r;
    assign out_first = main_first_r;

`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0] stall_cnt_r;

    // Count cycles where a live head is held back by downstream; saturates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (out_valid_r && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = {CNT_W{1'b0}};
`endif

endmodule
